// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the RV32I memory stage: access sizes, funct3
// encodings, FSM states and the write_back pipeline register layout.
package mem_access_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic              Rmem;
        logic              Wreg;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] memOut;
        logic [4:0]        rd;
    } mem_access_out_t;

    // The unsigned encodings only exist for loads; for stores they fall back to word.
    function automatic mem_size_t mem_size_f(input logic [2:0] f3, input logic is_load);
        mem_size_t s;
        case (f3)
            F3_LB:   s = BYTE;
            F3_LH:   s = HALF;
            F3_LBU:  s = is_load ? BYTE : WORD;
            F3_LHU:  s = is_load ? HALF : WORD;
            default: s = WORD;
        endcase
        return s;
    endfunction

    function automatic logic is_aligned_f(input mem_size_t size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            BYTE:    ok = 1'b1;
            HALF:    ok = ~addr_lo[0];
            WORD:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load lane extraction: picks the byte/halfword addressed within the read word
// and sign- or zero-extends it according to funct3.
module mem_access_load_align
    import mem_access_pkg::*;
(
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [2:0]        funct3_i,
    output logic [DATA_W-1:0] ext_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_s = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    // Extension select; unsupported encodings pass the whole word through.
    always_comb begin
        case (funct3_i)
            F3_LB:   ext_o = {{24{byte_s[7]}}, byte_s};
            F3_LH:   ext_o = {{16{half_s[15]}}, half_s};
            F3_LBU:  ext_o = {24'h00_0000, byte_s};
            F3_LHU:  ext_o = {16'h0000, half_s};
            default: ext_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// RV32I memory stage: drives the data-memory handshake, steers store lanes,
// extends loads and registers the write_back pipeline register.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              ex_valid,
    input  logic              ex_Rmem,
    input  logic              ex_Wmem,
    input  logic              ex_Wreg,
    input  logic [2:0]        ex_funct3,
    input  logic [XLEN-1:0]   ex_result,
    input  logic [XLEN-1:0]   ex_storeData,
    input  logic [4:0]        ex_rd,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              stall,
    output logic              misalign,
    output logic              Rmem,
    output logic              Wreg,
    output logic [XLEN-1:0]   result,
    output logic [XLEN-1:0]   memOut,
    output logic [4:0]        rd
);

    mem_state_t      state_q, state_d;
    mem_access_out_t out_q, out_d;
    logic            misalign_q, misalign_d;

    logic            mem_op_s, is_store_s, aligned_s, req_s;
    mem_size_t       size_s;
    logic [XLEN-1:0] load_ext_s;
    logic [XLEN-1:0] wdata_s;
    logic [3:0]      wstrb_s;

    assign mem_op_s   = ex_valid & (ex_Rmem | ex_Wmem);
    assign is_store_s = ex_Wmem & ~ex_Rmem;
    assign size_s     = mem_size_f(ex_funct3, ex_Rmem);
    assign aligned_s  = is_aligned_f(size_s, ex_result[1:0]);

    // Gated by nReset so the request drops the instant reset asserts mid-access.
    assign req_s      = nReset & ((state_q == BUSY) | (mem_op_s & aligned_s));

    assign dmem_req   = req_s;
    assign stall      = req_s & ~dmem_ack;
    assign dmem_we    = req_s & is_store_s;
    assign dmem_addr  = {ex_result[ADDR_W-1:2], 2'b00};
    assign dmem_wdata = wdata_s;
    assign dmem_wstrb = dmem_we ? wstrb_s : 4'b0000;

    mem_access_load_align u_load_align (
        .rdata_i   (dmem_rdata),
        .addr_lo_i (ex_result[1:0]),
        .funct3_i  (ex_funct3),
        .ext_o     (load_ext_s)
    );

    // Store lane replication and byte enables.
    always_comb begin
        case (size_s)
            BYTE: begin
                wdata_s = {4{ex_storeData[7:0]}};
                wstrb_s = 4'b0001 << ex_result[1:0];
            end
            HALF: begin
                wdata_s = {2{ex_storeData[15:0]}};
                wstrb_s = 4'b0011 << ex_result[1:0];
            end
            default: begin
                wdata_s = ex_storeData;
                wstrb_s = 4'b1111;
            end
        endcase
    end

    // Next state of the FSM and pipeline register; a bubble unless something retires.
    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        out_d.Rmem = 1'b0;
        out_d.Wreg = 1'b0;
        misalign_d = 1'b0;
        if (req_s) begin
            if (dmem_ack) begin
                state_d       = IDLE;
                out_d.Rmem    = ex_Rmem;
                out_d.Wreg    = ex_Wreg & ex_Rmem;
                out_d.result  = ex_result;
                out_d.memOut  = load_ext_s;
                out_d.rd      = ex_rd;
            end else begin
                state_d = BUSY;
            end
        end else if (mem_op_s) begin
            misalign_d = 1'b1;
        end else if (ex_valid) begin
            out_d.Wreg   = ex_Wreg;
            out_d.result = ex_result;
            out_d.rd     = ex_rd;
        end else begin
            out_d.Wreg = 1'b0;
        end
    end

    // FSM state and registered stage outputs.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q    <= IDLE;
            out_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            misalign_q <= misalign_d;
        end
    end

    assign Rmem     = out_q.Rmem;
    assign Wreg     = out_q.Wreg;
    assign result   = out_q.result;
    assign memOut   = out_q.memOut;
    assign rd       = out_q.rd;
    assign misalign = misalign_q;

endmodule
